// File: rtl/serial_adder.sv
// serial_adder_ha: single-bit half adder, the building block of the bit cell.
//   x, y : input bits
//   s    : sum bit (x ^ y)
//   c    : carry bit (x & y)
module serial_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// serial_adder: bit-serial two's-complement adder, LSB first, one bit per clk.
// A single full-adder cell (two half adders plus an OR) is reused across all
// WIDTH bits, so a result costs WIDTH cycles but only one cell of logic.
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   in_valid/ready  : operand handshake; in_ready is high only in IDLE
//   a, b, cin       : operands and carry-in, captured on acceptance
//   out_valid/ready : result handshake; result held until accepted
//   sum, cout, ovf  : a+b+cin mod 2^WIDTH, unsigned carry-out, signed overflow
//   busy            : high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | processing one bit per edge, counter tracks bit index
// DONE  | result presented on out_valid until out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  logic             ha0_s;
  logic             ha0_c;
  logic             bit_s;
  logic             ha1_c;
  logic             c_next;

  // Full-adder cell: HA(a,b) then HA(partial sum, carry), carries ORed.
  serial_adder_ha u_ha0 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  serial_adder_ha u_ha1 (
    .x (ha0_s),
    .y (carry),
    .s (bit_s),
    .c (ha1_c)
  );

  assign c_next   = ha0_c | ha1_c;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Handshake outputs decode straight from state so reset clears them at once.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
          psum  <= {bit_s, psum[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= {bit_s, psum[WIDTH-1:1]};
            cout <= c_next;
            // carry still holds the carry into the MSB at this edge
            ovf  <= carry ^ c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // WIDTH=8 instance
  logic       iv8 = 1'b0, ir8, cin8 = 1'b0, ov8, or8 = 1'b0, cout8, ovf8, busy8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  // WIDTH=2 instance
  logic       iv2 = 1'b0, ir2, cin2 = 1'b0, ov2, or2 = 1'b0, cout2, ovf2, busy2;
  logic [1:0] a2 = '0, b2 = '0, sum2;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
    .ovf(ovf8), .busy(busy8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(ov2), .out_ready(or2), .sum(sum2), .cout(cout2),
    .ovf(ovf2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint tot  = ua + ub + longint'(c);
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint st   = sa + sb + longint'(c);
    logic   ov   = (st >= half) || (st < -half);
    logic   co   = ((tot >> w) & 1) != 0;
    logic [63:0] s64 = tot & m;
    return {ov, co, s64[31:0]};
  endfunction

  // Compare processes: every cycle out_valid is high, outputs must equal the
  // model result for the oldest accepted, unconsumed transaction.
  logic [33:0] q8[$], q2[$];
  int          acc8[$], acc2[$];
  int          prev8 = -1, prev2 = -1, res8 = 0, res2 = 0;
  bit          seen8 = 0, seen2 = 0, btb8 = 0, btb2 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete(); acc8.delete(); seen8 = 0; prev8 = -1;
    end else begin
      if (!btb8) prev8 = -1;
      if (ov8) begin
        if (q8.size() == 0) check("ov8_unexpected", q8.size(), 1);
        else begin
          check("sum8", sum8, q8[0][7:0]);
          check("cout8", cout8, q8[0][32]);
          check("ovf8", ovf8, q8[0][33]);
          check("in_ready8_done", ir8, 0);
          if (!seen8) check("latency8", cyc - acc8[0], 8);
          seen8 = 1;
          if (or8) begin
            void'(q8.pop_front()); void'(acc8.pop_front()); seen8 = 0; res8++;
          end
        end
      end
      if (iv8 && ir8) begin
        q8.push_back(model(8, 32'(a8), 32'(b8), cin8));
        acc8.push_back(cyc + 1);
        if (prev8 >= 0) check("interval8", cyc + 1 - prev8, 10);
        prev8 = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete(); acc2.delete(); seen2 = 0; prev2 = -1;
    end else begin
      if (!btb2) prev2 = -1;
      if (ov2) begin
        if (q2.size() == 0) check("ov2_unexpected", q2.size(), 1);
        else begin
          check("sum2", sum2, q2[0][1:0]);
          check("cout2", cout2, q2[0][32]);
          check("ovf2", ovf2, q2[0][33]);
          if (!seen2) check("latency2", cyc - acc2[0], 2);
          seen2 = 1;
          if (or2) begin
            void'(q2.pop_front()); void'(acc2.pop_front()); seen2 = 0; res2++;
          end
        end
      end
      if (iv2 && ir2) begin
        q2.push_back(model(2, 32'(a2), 32'(b2), cin2));
        acc2.push_back(cyc + 1);
        if (prev2 >= 0) check("interval2", cyc + 1 - prev2, 4);
        prev2 = cyc + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    while (!ir8 && n < 40) begin step(); n++; end
    check("send8_ready", ir8, 1);
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    step();
    iv8 = 1'b0;
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (!ov8 && n < 40) begin step(); n++; end
  endtask

  task automatic consume8();
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    check("consume8_ov", ov8, 0);
    check("consume8_ir", ir8, 1);
  endtask

  logic [7:0] ta[4] = '{8'hFF, 8'h7F, 8'h80, 8'hFF};
  logic [7:0] tb[4] = '{8'h01, 8'h01, 8'h80, 8'hFF};
  logic       tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] es[4] = '{8'h00, 8'h80, 8'h00, 8'hFF};
  logic       ec[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic       eo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    int start;
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", sum8, 8'h00);
    check("rst_cout", cout8, 0);
    check("rst_ovf", ovf8, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ir", ir8, 1);
    check("post_rst_busy", busy8, 0);

    // Basic add with explicit latency count
    send8(8'h3C, 8'h05, 1'b0);
    check("busy_run", busy8, 1);
    wait8(n);
    check("lat_basic", n, 8);
    check("basic_sum", sum8, 8'h41);
    check("basic_cout", cout8, 0);
    check("basic_ovf", ovf8, 0);
    consume8();

    // Carry / overflow corners
    for (int i = 0; i < 4; i++) begin
      send8(ta[i], tb[i], tc[i]);
      wait8(n);
      check("corner_valid", ov8, 1);
      check("corner_sum", sum8, es[i]);
      check("corner_cout", cout8, ec[i]);
      check("corner_ovf", ovf8, eo[i]);
      consume8();
    end

    // Backpressure: result held, new operands ignored in DONE
    send8(8'h55, 8'h22, 1'b0);
    wait8(n);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h99; cin8 = 1'b1;
      step();
      check("bp_valid", ov8, 1);
      check("bp_ready", ir8, 0);
      check("bp_busy", busy8, 1);
      check("bp_sum", sum8, 8'h77);
      check("bp_cout", cout8, 0);
      check("bp_ovf", ovf8, 0);
    end
    iv8 = 1'b0;
    consume8();
    repeat (12) step();
    check("bp_nothing_queued", ov8, 0);

    // Operands toggling during RUN are ignored
    send8(8'h3A, 8'h4B, 1'b1);
    n = 0;
    while (!ov8 && n < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      step(); n++;
    end
    check("iso_sum", sum8, 8'h86);
    check("iso_cout", cout8, 0);
    check("iso_ovf", ovf8, 1);
    consume8();

    // Reset three edges into RUN aborts immediately
    send8(8'h12, 8'h34, 1'b0);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", ov8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_sum", sum8, 8'h00);
    check("mid_rst_ir", ir8, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    send8(8'h12, 8'h34, 1'b0);
    wait8(n);
    check("after_rst_lat", n, 8);
    check("after_rst_sum", sum8, 8'h46);
    consume8();

    // Back-to-back random, WIDTH=8
    btb8 = 1; iv8 = 1'b1; or8 = 1'b1;
    start = res8;
    for (int i = 0; i < 12000 && (res8 - start) < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      step();
    end
    check("btb8_count", res8 - start, 1000);
    iv8 = 1'b0;
    repeat (12) step();
    btb8 = 0; or8 = 1'b0;

    // WIDTH=2 hand-computed cases
    iv2 = 1'b1; a2 = 2'b01; b2 = 2'b01; cin2 = 1'b0;
    step(); iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 20) begin step(); n++; end
    check("w2_lat", n, 2);
    check("w2_sum_a", sum2, 2'b10);
    check("w2_cout_a", cout2, 0);
    check("w2_ovf_a", ovf2, 1);
    or2 = 1'b1; step(); or2 = 1'b0;
    iv2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    step(); iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 20) begin step(); n++; end
    check("w2_sum_b", sum2, 2'b11);
    check("w2_cout_b", cout2, 1);
    check("w2_ovf_b", ovf2, 0);
    or2 = 1'b1; step(); or2 = 1'b0;

    // Back-to-back random, WIDTH=2
    btb2 = 1; iv2 = 1'b1; or2 = 1'b1;
    start = res2;
    for (int i = 0; i < 6000 && (res2 - start) < 1000; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      step();
    end
    check("btb2_count", res2 - start, 1000);
    iv2 = 1'b0;
    repeat (6) step();
    btb2 = 0; or2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
